// File: rtl/slowmem_cache.sv
// ============================================================================
// slowmem_cache : direct-mapped, write-through, one-word-line cache in front
// of slowmem. Optional hit/miss counters when CACHE_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module slowmem_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rnotw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              hit,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rnotw,
  output logic              mem_strobe,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
  output logic [15:0]       hits,
  output logic [15:0]       misses,
`endif
  input  logic              mem_mfc
);

  localparam int LINES = 2 ** IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR      = 2'd3
  } state_t;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic                r_flush_pend;
  logic [TAG_W-1:0]    r_tag_mem  [LINES];
  logic [DATA_W-1:0]   r_data_mem [LINES];
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_hit;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_rnotw;
  logic                r_mem_strobe;

  logic [IDX_W-1:0]    w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_fill_idx;
  logic [TAG_W-1:0]    w_fill_tag;
  logic                w_lookup_hit;

  assign w_idx      = addr[IDX_W-1:0];
  assign w_tag      = addr[ADDR_W-1:IDX_W];
  // The miss address is held in mem_addr for the whole fill.
  assign w_fill_idx = r_mem_addr[IDX_W-1:0];
  assign w_fill_tag = r_mem_addr[ADDR_W-1:IDX_W];
  // A flush in the lookup cycle wins: the request sees an empty cache.
  assign w_lookup_hit = r_valid[w_idx] && (r_tag_mem[w_idx] == w_tag) && !flush;

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && req && !rnotw && w_lookup_hit) begin
      r_data_mem[w_idx] <= wdata;
    end else if (r_state == S_RD_WAIT && mem_mfc) begin
      r_data_mem[w_fill_idx] <= mem_rdata;
      r_tag_mem[w_fill_idx]  <= w_fill_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_rdata      <= '0;
      r_ready      <= 1'b0;
      r_hit        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_rnotw  <= 1'b0;
      r_mem_strobe <= 1'b0;
    end else begin
      r_ready      <= 1'b0;
      r_hit        <= 1'b0;
      r_mem_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= '0;
          if (req) begin
            if (!rnotw) begin
              r_state      <= S_WR;
              r_mem_strobe <= 1'b1;
              r_mem_rnotw  <= 1'b0;
              r_mem_addr   <= addr;
              r_mem_wdata  <= wdata;
              r_ready      <= 1'b1;
              r_hit        <= w_lookup_hit;
            end else if (w_lookup_hit) begin
              r_ready <= 1'b1;
              r_hit   <= 1'b1;
              r_rdata <= r_data_mem[w_idx];
            end else begin
              r_state      <= S_RD_REQ;
              r_mem_strobe <= 1'b1;
              r_mem_rnotw  <= 1'b1;
              r_mem_addr   <= addr;
            end
          end
        end
        S_RD_REQ: begin
          if (flush) r_flush_pend <= 1'b1;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (flush) r_flush_pend <= 1'b1;
          if (mem_mfc) begin
            r_rdata      <= mem_rdata;
            r_ready      <= 1'b1;
            r_state      <= S_IDLE;
            r_flush_pend <= 1'b0;
            // A pending flush also kills the line being filled right now.
            if (flush || r_flush_pend) r_valid <= '0;
            else                       r_valid[w_fill_idx] <= 1'b1;
          end
        end
        S_WR: begin
          r_state      <= S_IDLE;
          r_flush_pend <= 1'b0;
          if (flush || r_flush_pend) r_valid <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata      = r_rdata;
  assign ready      = r_ready;
  assign hit        = r_hit;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_rnotw  = r_mem_rnotw;
  assign mem_strobe = r_mem_strobe;

`ifdef CACHE_STATS_EN
  logic [15:0] r_hits;
  logic [15:0] r_misses;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_ready) begin
      if (r_hit && r_hits != 16'hffff)          r_hits   <= r_hits + 16'd1;
      else if (!r_hit && r_misses != 16'hffff)  r_misses <= r_misses + 16'd1;
    end
  end

  assign hits   = r_hits;
  assign misses = r_misses;
`endif

endmodule

`default_nettype wire
